ei_axi4_slave_wr_mem: RTL and testbench

- Synthesizable AXI4 write-path slave with internal byte-addressable memory.
- Sits directly downstream of the master VIP interface in the AXI4 bench. Consumes AW/W traffic, returns B responses.
- Serves as the first real DUT the VIP drives.
- Includes a backdoor debug read port so the scoreboard can check memory contents without using the bus.

---
 rtl/ei_axi4_slave_wr_mem.sv | 200 ++++++++++++++++++++
 tb/tb_ei_axi4_slave_wr_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_axi4_slave_wr_mem.sv
// AXI4 write-path slave backed by a byte-lane-writable memory, with a backdoor read port.
// Optional macro EI_AXI4_SLV_BRESP_DELAY_EN inserts B_DELAY wait cycles before each B response.
module ei_axi4_slave_wr_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int B_DELAY    = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WI_W   = ADDR_WIDTH - LSB;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam logic [2:0] MAX_SIZE = 3'(LSB);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
  localparam int MIN_DELAY = 1;
`else
  localparam int MIN_DELAY = 0;
`endif

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (MEM_DEPTH != (1 << IDX_W) || WI_W < IDX_W) begin : g_bad_depth
    $error("MEM_DEPTH must be a power of 2 addressable by ADDR_WIDTH");
  end
  if (B_DELAY < MIN_DELAY) begin : g_bad_delay
    $error("B_DELAY too small");
  end

  typedef enum logic [2:0] {
    ST_RST, ST_IDLE, ST_DATA, ST_RESP
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
    , ST_WAIT
`endif
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            beat_cnt;
  logic                  err_q;   // response will be SLVERR
  logic                  sup_q;   // whole burst rejected at AW, no writes
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
  logic [7:0]            dly_cnt;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AW1-1:0]   bytes, total, boundary, align, addr_inc;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [WI_W-1:0]  word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic in_range, beat, last_beat, end_burst, end_err, aw_err, mem_we;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    bytes     = AW1'(1) << size_q;
    total     = bytes * AW1'({1'b0, len_q} + 9'd1);
    boundary  = {1'b0, addr_q} & ~(total - AW1'(1));
    align     = {1'b0, addr_q} & ~(bytes - AW1'(1));
    addr_inc  = {1'b0, addr_q} + bytes;
    next_addr = addr_q;
    case (burst_q)
      BURST_INCR: next_addr = ADDR_WIDTH'(align + bytes);
      BURST_WRAP: next_addr = (addr_inc >= boundary + total) ? ADDR_WIDTH'(boundary)
                                                             : ADDR_WIDTH'(addr_inc);
      default:    next_addr = addr_q;
    endcase

    word_idx  = addr_q[ADDR_WIDTH-1:LSB];
    mem_idx   = word_idx[IDX_W-1:0];
    in_range  = (word_idx >> IDX_W) == '0;
    beat      = wvalid && wready;
    last_beat = beat_cnt == len_q;
    end_burst = last_beat || wlast;
    end_err   = err_q || !in_range || (last_beat != wlast);
    // Beats arriving in the same cycle reset is asserted are not committed.
    mem_we    = beat && aresetn && !sup_q && in_range;

    aw_err = (awsize > MAX_SIZE) || (awburst == 2'b11) ||
             (awburst == BURST_WRAP &&
              !(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15));
  end

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= ST_RST;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      sup_q    <= 1'b0;
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
      dly_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_RST: begin
          state   <= ST_IDLE;
          awready <= 1'b1;
        end
        ST_IDLE: if (awvalid) begin
          id_q     <= awid;
          addr_q   <= awaddr;
          len_q    <= awlen;
          size_q   <= awsize;
          burst_q  <= awburst;
          beat_cnt <= '0;
          err_q    <= aw_err;
          sup_q    <= aw_err;
          awready  <= 1'b0;
          wready   <= 1'b1;
          state    <= ST_DATA;
        end
        ST_DATA: if (wvalid) begin
          addr_q <= next_addr;
          if (end_burst) begin
            wready <= 1'b0;
            err_q  <= end_err;
            bid    <= id_q;
            bresp  <= end_err ? RESP_SLVERR : RESP_OKAY;
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
            dly_cnt <= '0;
            state   <= ST_WAIT;
`else
            bvalid <= 1'b1;
            state  <= ST_RESP;
`endif
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            err_q    <= err_q || !in_range;
          end
        end
`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
        ST_WAIT: begin
          if (dly_cnt == 8'(B_DELAY - 1)) begin
            bvalid <= 1'b1;
            state  <= ST_RESP;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
`endif
        ST_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_RST;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive aresetn by design.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[mem_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_ei_axi4_slave_wr_mem.sv
// Self-checking bench for ei_axi4_slave_wr_mem: table of bursts, B-response scoreboard,
// plus hand-written backpressure and mid-burst reset sequences.
module tb_ei_axi4_slave_wr_mem;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  ei_axi4_slave_wr_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]        id;
    logic [15:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                nbeats;
    logic              wlast_end;
    logic [3:0][31:0]  data;
    logic [3:0][3:0]   strb;
    logic [1:0]        resp;
    int                nchk;
    logic [3:0][7:0]   chk_idx;
    logic [3:0][31:0]  chk_val;
  } vec_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  vec_t   vecs[11];
  b_exp_t sb[$];
  int tests = 0, fails = 0, pushes = 0, b_hs = 0;

`ifdef EI_AXI4_SLV_BRESP_DELAY_EN
  localparam logic BV_AT_U1 = 1'b0;
`else
  localparam logic BV_AT_U1 = 1'b1;
`endif

  always @(posedge aclk) if (bvalid === 1'b1 && bready === 1'b1) b_hs++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within bound, required one", name);
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                              input logic wlast_end, input logic [3:0][31:0] data,
                              input logic [3:0][3:0] strb, input logic [1:0] resp, input int nchk,
                              input logic [3:0][7:0] chk_idx, input logic [3:0][31:0] chk_val);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.nbeats = nbeats; v.wlast_end = wlast_end; v.data = data; v.strb = strb;
    v.resp = resp; v.nchk = nchk; v.chk_idx = chk_idx; v.chk_val = chk_val;
    return v;
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    if (awready !== 1'b1) timeout("aw_handshake");
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic mem_chk(input string name, input logic [7:0] idx, input logic [31:0] val);
    dbg_addr = idx;
    #1;
    check(name, 64'(dbg_rdata), 64'(val));
  endtask

  task automatic get_b(input string name);
    int n = 0;
    b_exp_t e;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < 40) begin @(negedge aclk); n++; end
    if (bvalid !== 1'b1) begin
      timeout({name, "_bvalid"});
    end else if (sb.size() == 0) begin
      timeout({name, "_unexpected_b"});
    end else begin
      e = sb.pop_front();
      check({name, "_bid"}, 64'(bid), 64'(e.id));
      check({name, "_bresp"}, 64'(bresp), 64'(e.resp));
    end
    @(negedge aclk);
    bready = 1'b0;
    check({name, "_awready_after_b"}, 64'(awready), 64'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int stalls = 0;
    int n;
    sb.push_back('{id: v.id, resp: v.resp});
    pushes++;
    send_aw(v.id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b < v.nbeats; b++) begin
      wdata = v.data[b]; wstrb = v.strb[b];
      wlast = (b == v.nbeats - 1) ? v.wlast_end : 1'b0;
      wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
      stalls += n;
      if (wready !== 1'b1) begin timeout({name, "_w"}); break; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({name, "_wready_stalls"}, 64'(stalls), 64'd0);
    check({name, "_bvalid_latency"}, 64'(bvalid), 64'(BV_AT_U1));
    get_b(name);
    for (int c = 0; c < v.nchk; c++) mem_chk({name, "_mem"}, v.chk_idx[c], v.chk_val[c]);
  endtask

  initial begin
    int bad;
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0; dbg_addr = '0;

    vecs[0]  = mk(4'd0, 16'h0068, 8'd1, 3'd2, 2'd1, 2, 1'b1, {32'h0, 32'h0, 32'hAAAA0002, 32'hAAAA0001},
                  {4'h0, 4'h0, 4'hF, 4'hF}, 2'b00, 2, {8'd0, 8'd0, 8'd27, 8'd26}, {32'h0, 32'h0, 32'hAAAA0002, 32'hAAAA0001});
    vecs[1]  = mk(4'd5, 16'h0010, 8'd0, 3'd2, 2'd1, 1, 1'b1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                  {4'h0, 4'h0, 4'h0, 4'hF}, 2'b00, 1, {8'd0, 8'd0, 8'd0, 8'd4}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF});
    vecs[2]  = mk(4'd1, 16'h0020, 8'd3, 3'd2, 2'd1, 4, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1},
                  {4'hF, 4'hF, 4'hF, 4'hF}, 2'b00, 4, {8'd11, 8'd10, 8'd9, 8'd8}, {32'd4, 32'd3, 32'd2, 32'd1});
    vecs[3]  = mk(4'd2, 16'h0038, 8'd3, 3'd2, 2'd2, 4, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA},
                  {4'hF, 4'hF, 4'hF, 4'hF}, 2'b00, 4, {8'd13, 8'd12, 8'd15, 8'd14}, {32'hD, 32'hC, 32'hB, 32'hA});
    vecs[4]  = mk(4'd3, 16'h0040, 8'd3, 3'd2, 2'd0, 4, 1'b1, {32'h44000000, 32'h00330000, 32'h00002200, 32'h00000011},
                  {4'h8, 4'h4, 4'h2, 4'h1}, 2'b00, 1, {8'd0, 8'd0, 8'd0, 8'd16}, {32'h0, 32'h0, 32'h0, 32'h44332211});
    vecs[5]  = mk(4'd4, 16'h0060, 8'd3, 3'd2, 2'd1, 2, 1'b1, {32'h0, 32'h0, 32'h52, 32'h51},
                  {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10, 3, {8'd0, 8'd26, 8'd25, 8'd24}, {32'h0, 32'hAAAA0001, 32'h52, 32'h51});
    vecs[6]  = mk(4'd6, 16'h0010, 8'd0, 3'd3, 2'd1, 1, 1'b1, {32'h0, 32'h0, 32'h0, 32'h12345678},
                  {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10, 1, {8'd0, 8'd0, 8'd0, 8'd4}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF});
    vecs[7]  = mk(4'd7, 16'h0020, 8'd0, 3'd2, 2'd3, 1, 1'b1, {32'h0, 32'h0, 32'h0, 32'h99},
                  {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10, 1, {8'd0, 8'd0, 8'd0, 8'd8}, {32'h0, 32'h0, 32'h0, 32'd1});
    vecs[8]  = mk(4'd8, 16'h0020, 8'd2, 3'd2, 2'd2, 3, 1'b1, {32'h0, 32'h55, 32'h66, 32'h77},
                  {4'h0, 4'hF, 4'hF, 4'hF}, 2'b10, 3, {8'd0, 8'd10, 8'd9, 8'd8}, {32'h0, 32'd3, 32'd2, 32'd1});
    vecs[9]  = mk(4'd9, 16'h03FC, 8'd1, 3'd2, 2'd1, 2, 1'b1, {32'h0, 32'h0, 32'hBBBB0002, 32'hBBBB0001},
                  {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10, 1, {8'd0, 8'd0, 8'd0, 8'd255}, {32'h0, 32'h0, 32'h0, 32'hBBBB0001});
    vecs[10] = mk(4'd10, 16'h0050, 8'd0, 3'd2, 2'd1, 1, 1'b0, {32'h0, 32'h0, 32'h0, 32'hC0FFEE00},
                  {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10, 1, {8'd0, 8'd0, 8'd0, 8'd20}, {32'h0, 32'h0, 32'h0, 32'hC0FFEE00});

    repeat (3) @(negedge aclk);
    check("reset_outputs", 64'({awready, wready, bvalid, bid, bresp}), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("awready_after_reset", 64'(awready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: bready held low, response must stay put and no new AW accepted.
    sb.push_back('{id: 4'hC, resp: 2'b00});
    pushes++;
    send_aw(4'hC, 16'h0080, 8'd0, 3'd2, 2'd1);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    for (int n = 0; n < 20 && bvalid !== 1'b1; n++) @(negedge aclk);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (bvalid !== 1'b1 || bid !== 4'hC || bresp !== 2'b00 || awready !== 1'b0) bad++;
      @(negedge aclk);
    end
    check("bp_stable_cycles_bad", 64'(bad), 64'd0);
    get_b("bp");
    mem_chk("bp_mem", 8'd32, 32'hCAFEF00D);

    // Reset asserted during beat 2: no response, beat 1 stays in memory.
    send_aw(4'hB, 16'h00A0, 8'd3, 3'd2, 2'd1);
    wdata = 32'h1111; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wdata = 32'h2222;
    aresetn = 1'b0;
    @(negedge aclk);
    wvalid = 1'b0;
    check("midreset_outputs", 64'({awready, wready, bvalid, bid, bresp}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    bad = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge aclk);
      if (bvalid !== 1'b0) bad++;
    end
    check("midreset_awready", 64'(awready), 64'd1);
    bready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge aclk);
      if (bvalid !== 1'b0) bad++;
    end
    bready = 1'b0;
    check("midreset_no_bvalid", 64'(bad), 64'd0);
    mem_chk("midreset_mem", 8'd40, 32'h1111);

    run_vec("post_reset", vecs[2]);

    check("b_handshakes", 64'(b_hs), 64'(pushes));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
